aes_key_sched_stream: RTL and testbench
=======================================

# aes_key_sched_stream

Iterative AES key-schedule generator for AES-128, AES-192 and AES-256. It accepts one cipher key over a valid/ready handshake. It then streams all round keys in order, one 128-bit round key per output beat, with full backpressure. It sits between the key-load interface and a round-pipelined cipher core, and replaces the fixed-width, two-stage AES-256-only round-key stage.

## Interface
- `max_nk_p`, default 8: largest key length supported, in 32-bit words (4, 6 or 8). Sets the `key_i` width and the history depth.
- `clk_i`  in  1  clock, rising edge.
- `reset_n_i`  in  1  reset; one clock, reset is asynchronous and active-low.
- `v_i`  in  1  key valid.
- `ready_o`  out  1  block can accept a key; high only in IDLE.
- `key_i`  in  32*max_nk_p  cipher key. Word 0 is in the most significant 32 bits. For AES-128 and AES-192 the key is left-justified and the unused low words are ignored.
- `mode_i`  in  2  key size: 0 = 128, 1 = 192, 2 = 256, 3 = reserved.
- `v_o`  out  1  round key valid.
- `ready_i`  in  1  consumer accepts the round key.
- `rkey_o`  out  128  round key; word 0 is in the MSBs.
- `round_o`  out  4  round index, 0..Nr.
- `last_o`  out  1  high with round Nr.
- `err_o`  out  1  one-cycle pulse when a key is rejected.

## Operation
- Nk and Nr are derived from the mode: Nk = 4, 6, 8 and Nr = 10, 12, 14.
- Key words: w[i] = key word i for i < Nk.
- Generated words: w[i] = w[i-Nk] ^ t.
  - If i mod Nk = 0: t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}.
  - If Nk = 8 and i mod 8 = 4: t = SubWord(w[i-1]).
  - Otherwise: t = w[i-1].
- Each beat produces four words, w[4r] to w[4r+3]. Any 4-word group contains at most one SubWord position, so only one 4-byte S-box instance exists, and it is muxed onto the selected word.
- Within a beat the four words are chained combinationally, so a word may depend on one computed earlier in the same beat.
- History register: the last 8 generated words. Both w[i-Nk] and w[i-1] are read from history or from the current chain.
- Rcon register:
  - Loads 8'h01 on key accept.
  - Advances by xtime (01, 02, …, 80, 1B, 36) after each use.
  - The 8-bit overflow reduction by 8'h1B is mandatory.
- States:
  - IDLE: `ready_o` = 1. On `v_i` with mode 0–2: latch the key and mode, clear the word counter, go to RUN. On mode 3, or Nk > `max_nk_p`: pulse `err_o`, stay in IDLE.
  - RUN: `v_o` = 1. On `v_o & ready_i`: advance the word counter by 4 and load the next round key into the output register. On the beat where `last_o` is high, return to IDLE.
- `v_i` in RUN is ignored (`ready_o` = 0); no key is lost because the producer must hold `v_i`.

## Timing
- Reset values: `v_o` = 0, `rkey_o` = 0, `round_o` = 0, `last_o` = 0, `err_o` = 0, `ready_o` = 1, state = IDLE, rcon = 01.
- Latency: key accepted at edge N gives round 0 on `rkey_o` with `v_o` = 1 from cycle N+1.
- Throughput: one round key per cycle while `ready_i` = 1.
- Backpressure: `rkey_o`, `round_o` and `last_o` stay stable while `v_o & !ready_i`.
- A full key takes Nr+1 beats. `ready_o` rises in the cycle after the last beat's handshake, so the minimum key-to-key spacing is Nr+2 cycles.
- `err_o` is asserted in the cycle after the rejected handshake, for one cycle only.
- Async reset mid-stream: `v_o` drops immediately and the partial schedule is discarded. After reset is released, the block accepts a new key.

## Structure
- Shared package `aes_pkg`:
  - `aes_mode_e` enum.
  - Nk/Nr lookup functions.
  - `xtime` function.
  - S-box constant.
- The existing `sub_bytes #(4)` is reused for SubWord.
- One natural sub-module: `aes_word_chain`, the combinational 4-word generator with its S-box mux, instantiated once.

## Test plan
- AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, `ready_i` = 1:
  - Round 1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - Round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, with `last_o` = 1.
  - 11 beats on consecutive cycles.
- AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b: round 12 = e98ba06f 448c773c 8ecc7204 01002202, 13 beats.
- AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4: round 14 = fe4890d1 e6188d0b 046df344 706c631e, 15 beats.
- Random `ready_i` stalls during the AES-128 run: outputs are held stable while stalled, and the key sequence is identical to the unstalled run.
- `mode_i` = 3 with `v_i`: one-cycle `err_o` pulse, `v_o` stays 0, and a subsequent valid key is accepted normally.
- `reset_n_i` pulsed low at round 5: `v_o` falls asynchronously, and after release the AES-256 vector completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size modes, Nk/Nr lookup,
// GF(2^8) doubling and the forward S-box.
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_128 = 2'd0,
        MODE_192 = 2'd1,
        MODE_256 = 2'd2,
        MODE_RSV = 2'd3
    } aes_mode_e;

    function automatic logic [3:0] nk_of(input aes_mode_e m);
        case (m)
            MODE_192: return 4'd6;
            MODE_256: return 4'd8;
            default:  return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input aes_mode_e m);
        case (m)
            MODE_192: return 4'd12;
            MODE_256: return 4'd14;
            default:  return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

endpackage

// File: rtl/aes_word_chain.sv
// Combinational generator of the next four schedule words,
// sharing one SubWord S-box across the beat.
module aes_word_chain (
    input  logic [0:7][31:0] hist,
    input  logic [0:3][31:0] key_hi,
    input  logic             first,
    input  logic [3:0]       nk,
    input  logic [2:0]       pos,
    input  logic [7:0]       rcon,
    output logic [0:3][31:0] words,
    output logic             rcon_used
);

    logic [3:0]       key_j;
    logic             sub_en;
    logic             rot;
    logic [1:0]       js;
    logic [0:4][31:0] ea;
    logic [0:4][31:0] eb;
    logic [31:0]      sb_in;
    logic [31:0]      sb_out;

    // find the one slot needing SubWord; key words pass through
    always_comb begin
        int p;
        p      = 0;
        sub_en = 1'b0;
        rot    = 1'b0;
        js     = 2'd0;
        key_j  = '0;
        for (int j = 0; j < 4; j++) begin
            p = int'(pos) + j;
            if (p >= int'(nk)) p = p - int'(nk);
            key_j[j] = first && (4 + j < int'(nk));
            if (!key_j[j]) begin
                if (p == 0) begin
                    sub_en = 1'b1;
                    rot    = 1'b1;
                    js     = 2'(j);
                end else if (nk == 4'd8 && p == 4) begin
                    sub_en = 1'b1;
                    js     = 2'(j);
                end
            end
        end
    end

    // words ahead of the S-box slot never use it, so this
    // plain chain gives the S-box input without a loop
    always_comb begin
        ea[0] = hist[7];
        for (int j = 0; j < 4; j++) begin
            ea[j+1] = key_j[j] ? key_hi[j]
                    : hist[3'(8 + j - int'(nk))] ^ ea[j];
        end
        sb_in = rot ? {ea[js][23:0], ea[js][31:24]} : ea[js];
    end

    sub_bytes #(.n_bytes_p(4)) u_sbox (
        .val (sb_in),
        .res (sb_out)
    );

    // final chain with the substituted word spliced in
    always_comb begin
        logic [31:0] t;
        t         = '0;
        eb[0]     = hist[7];
        rcon_used = sub_en && rot;
        for (int j = 0; j < 4; j++) begin
            t = eb[j];
            if (sub_en && js == 2'(j)) begin
                t = sb_out ^ (rot ? {rcon, 24'h0} : 32'h0);
            end
            eb[j+1] = key_j[j] ? key_hi[j]
                    : hist[3'(8 + j - int'(nk))] ^ t;
        end
        words = eb[1:4];
    end

endmodule

// File: rtl/sub_bytes.sv
// Byte-wise forward S-box substitution over an
// n-byte word.
module sub_bytes
    import aes_pkg::*;
#(
    parameter int n_bytes_p = 4
) (
    input  logic [8*n_bytes_p-1:0] val,
    output logic [8*n_bytes_p-1:0] res
);

    // look up every byte independently
    always_comb begin
        res = '0;
        for (int b = 0; b < n_bytes_p; b++) begin
            res[8*b +: 8] = SBOX[val[8*b +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_sched_stream.sv
// Iterative AES-128/192/256 key schedule streaming one
// 128-bit round key per beat with full backpressure.
module aes_key_sched_stream
    import aes_pkg::*;
#(
    parameter int max_nk_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [32*max_nk_p-1:0] key_i,
    input  logic [1:0]             mode_i,
    output logic                   v_o,
    input  logic                   ready_i,
    output logic [127:0]           rkey_o,
    output logic [3:0]             round_o,
    output logic                   last_o,
    output logic                   err_o
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q;
    state_e           state_d;
    logic             accept;
    logic             reject;
    logic             advance;
    logic             bad;
    logic [255:0]     key_full;
    aes_mode_e        mode;
    logic [3:0]       nk_in;
    logic [3:0]       nr_in;
    logic [3:0]       nk_q;
    logic [3:0]       nr_q;
    logic [3:0]       pos_nxt;
    logic [2:0]       pos_q;
    logic [7:0]       rcon_q;
    logic [0:7][31:0] hist_q;
    logic [0:3][31:0] key_hi_q;
    logic [0:3][31:0] words;
    logic             rcon_used;

    assign key_full = 256'(key_i) << (256 - 32*max_nk_p);
    assign mode     = aes_mode_e'(mode_i);
    assign nk_in    = nk_of(mode);
    assign nr_in    = nr_of(mode);
    assign bad      = (mode == MODE_RSV) || (int'(nk_in) > max_nk_p);
    assign v_o      = (state_q == RUN);

    aes_word_chain u_chain (
        .hist      (hist_q),
        .key_hi    (key_hi_q),
        .first     (round_o == 4'd0),
        .nk        (nk_q),
        .pos       (pos_q),
        .rcon      (rcon_q),
        .words     (words),
        .rcon_used (rcon_used)
    );

    // state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // next state and handshake decode
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        advance = 1'b0;
        ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) begin
                    if (bad) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (ready_i) begin
                    advance = 1'b1;
                    if (last_o) state_d = IDLE;
                end
            end
            default: ;
        endcase
    end

    // word position within Nk for the next beat
    always_comb begin
        pos_nxt = {1'b0, pos_q} + 4'd4;
        if (pos_nxt >= nk_q) pos_nxt = pos_nxt - nk_q;
    end

    // key latch, history shift and output round key
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rkey_o   <= '0;
            round_o  <= '0;
            last_o   <= 1'b0;
            err_o    <= 1'b0;
            rcon_q   <= 8'h01;
            nk_q     <= 4'd4;
            nr_q     <= 4'd10;
            pos_q    <= '0;
            hist_q   <= '0;
            key_hi_q <= '0;
        end else begin
            err_o <= reject;
            if (accept) begin
                rkey_o   <= key_full[255:128];
                round_o  <= '0;
                last_o   <= 1'b0;
                rcon_q   <= 8'h01;
                nk_q     <= nk_in;
                nr_q     <= nr_in;
                pos_q    <= (nk_in == 4'd4) ? 3'd0 : 3'd4;
                hist_q   <= {128'h0, key_full[255:128]};
                key_hi_q <= key_full[127:0];
            end else if (advance && !last_o) begin
                rkey_o  <= words;
                round_o <= round_o + 4'd1;
                last_o  <= (round_o + 4'd1 == nr_q);
                hist_q  <= {hist_q[4:7], words};
                pos_q   <= pos_nxt[2:0];
                if (rcon_used) rcon_q <= xtime(rcon_q);
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_stream.sv
// Bench for aes_key_sched_stream: directed vectors plus
// random keys against a word-level key-expansion model.
module tb_aes_key_sched_stream;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         v_i = 1'b0;
    logic         ready_o;
    logic [255:0] key_i = '0;
    logic [1:0]   mode_i = 2'd0;
    logic         v_o;
    logic         ready_i = 1'b1;
    logic [127:0] rkey_o;
    logic [3:0]   round_o;
    logic         last_o;
    logic         err_o;

    aes_key_sched_stream #(.max_nk_p(8)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .key_i     (key_i),
        .mode_i    (mode_i),
        .v_o       (v_o),
        .ready_i   (ready_i),
        .rkey_o    (rkey_o),
        .round_o   (round_o),
        .last_o    (last_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [15];
    logic [127:0] got [16];
    logic [127:0] base128 [16];
    int           beats;
    int           cycles;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int k = 0; k < 8; k++) if (b[k]) prod ^= (16'(a) << k);
        for (int k = 15; k >= 8; k--) if (prod[k]) prod ^= (16'h011b << (k - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] x);
        return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIPS-197 key expansion on whole words
    task automatic model(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // called at a falling edge; returns at a falling edge
    task automatic run_key(input logic [255:0] key, input logic [1:0] mode,
                           input int stall_pct, input string tag);
        int           nr;
        logic         held;
        logic [127:0] h_key;
        logic [3:0]   h_round;
        logic         h_last;
        nr = 10 + 2*int'(mode);
        model(key, 4 + 2*int'(mode));
        chk({tag, "_ready"}, 128'(ready_o), 128'(1));
        v_i = 1'b1; key_i = key; mode_i = mode;
        @(negedge clk);
        v_i = 1'b0; key_i = ~key;
        chk({tag, "_lat_v"}, 128'(v_o), 128'(1));
        chk({tag, "_lat_round"}, 128'(round_o), 128'(0));
        beats = 0; cycles = 0; held = 1'b0;
        h_key = '0; h_round = '0; h_last = 1'b0;
        while (beats <= nr && cycles < 400) begin
            if (cycles > 0) @(negedge clk);
            cycles++;
            if (held) begin
                chk({tag, "_hold_key"}, rkey_o, h_key);
                chk({tag, "_hold_round"}, 128'(round_o), 128'(h_round));
                chk({tag, "_hold_last"}, 128'(last_o), 128'(h_last));
            end
            chk({tag, "_v"}, 128'(v_o), 128'(1));
            ready_i = ($urandom_range(99) >= stall_pct);
            if (ready_i) begin
                got[beats] = rkey_o;
                chk($sformatf("%s_round%0d", tag, beats), 128'(round_o), 128'(beats));
                chk($sformatf("%s_last%0d", tag, beats), 128'(last_o), 128'(beats == nr));
                beats++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                h_key = rkey_o; h_round = round_o; h_last = last_o;
            end
        end
        chk({tag, "_beats"}, 128'(beats), 128'(nr + 1));
        if (stall_pct == 0) chk({tag, "_cycles"}, 128'(cycles), 128'(nr + 1));
        @(negedge clk);
        ready_i = 1'b1;
        chk({tag, "_idle_v"}, 128'(v_o), 128'(0));
        chk({tag, "_idle_ready"}, 128'(ready_o), 128'(1));
        for (int r = 0; r <= nr; r++) chk($sformatf("%s_rk%0d", tag, r), got[r], exp_rk[r]);
    endtask

    initial begin
        logic [255:0] k128;
        logic [255:0] k192;
        logic [255:0] k256;
        logic [255:0] rk;
        logic [7:0]   inv;
        int           n;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end

        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                $urandom, $urandom, $urandom, $urandom};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                $urandom, $urandom};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

        #12;
        chk("rst_v", 128'(v_o), 128'(0));
        chk("rst_rkey", rkey_o, 128'(0));
        chk("rst_round", 128'(round_o), 128'(0));
        chk("rst_last", 128'(last_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        chk("rst_ready", 128'(ready_o), 128'(1));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_key(k128, 2'd0, 0, "a128");
        for (int r = 0; r < 11; r++) base128[r] = got[r];
        chk("a128_kat_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("a128_kat_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_key(k128, 2'd0, 40, "a128s");
        for (int r = 0; r < 11; r++) chk($sformatf("a128s_same%0d", r), got[r], base128[r]);

        run_key(k192, 2'd1, 0, "a192");
        chk("a192_kat_r12", got[12], 128'he98ba06f448c773c8ecc720401002202);

        run_key(k256, 2'd2, 0, "a256");
        chk("a256_kat_r14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        for (int i = 0; i < 6; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
            run_key(rk, 2'(i % 3), 25, $sformatf("rnd%0d", i));
        end

        v_i = 1'b1; mode_i = 2'd3;
        key_i = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        v_i = 1'b0;
        chk("err_pulse", 128'(err_o), 128'(1));
        chk("err_v", 128'(v_o), 128'(0));
        chk("err_ready", 128'(ready_o), 128'(1));
        @(negedge clk);
        chk("err_one_cycle", 128'(err_o), 128'(0));
        chk("err_v2", 128'(v_o), 128'(0));
        rk = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
        run_key(rk, 2'd1, 0, "after_err");

        v_i = 1'b1; mode_i = 2'd2; key_i = k256;
        @(negedge clk);
        v_i = 1'b0; ready_i = 1'b1;
        n = 0;
        while (round_o != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reach5", 128'(round_o), 128'(5));
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_v", 128'(v_o), 128'(0));
        chk("rst_mid_ready", 128'(ready_o), 128'(1));
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_mid_round", 128'(round_o), 128'(0));
        chk("rst_mid_rkey", rkey_o, 128'(0));
        run_key(k256, 2'd2, 0, "a256_post");
        chk("a256_post_kat", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
